// File: rtl/counter4_sequencer.sv
// Command sequencer for a Counter4 4-bit counter/shift register.
// The host queues {mode, data, rep, sin} commands into a small FIFO.
// Each command drives the register controls for rep+1 cycles.
// Commands run back-to-back, and done pulses after each command finishes.
module counter4_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Ck,
  input  logic          Reset,
  input  logic          abort,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_mode,
  input  logic [3:0]    cmd_data,
  input  logic [3:0]    cmd_rep,
  input  logic          cmd_sin,
  output logic [2:0]    Mode,
  output logic [3:0]    Din,
  output logic          R_In,
  output logic          L_In,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   level
);

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] data;
    logic [3:0] rep;
    logic       sin;
  } cmd_t;

  localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

  cmd_t          fifoMem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   level_q, level_d;

  state_t        state_q, state_d;
  logic [3:0]    remain_q, remain_d;
  logic [2:0]    mode_q, mode_d;
  logic [3:0]    din_q, din_d;
  logic          sin_q, sin_d;
  logic          done_q, done_d;

  logic          push, pop, fifoEmpty;
  cmd_t          inCmd, headCmd;

  assign fifoEmpty = (level_q == '0);
  assign cmd_ready = (level_q != LevelFull) && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign inCmd     = '{mode: cmd_mode, data: cmd_data, rep: cmd_rep, sin: cmd_sin};
  assign headCmd   = fifoMem_q[rdPtr_q];

  // Store an accepted command at the write pointer; the storage needs no reset
  always_ff @(posedge Ck) begin
    if (push) fifoMem_q[wrPtr_q] <= inCmd;
  end

  // Track occupancy: a simultaneous push and pop cancel out
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (pop && !push) level_d = level_q - (AW+1)'(1);
  end

  // FIFO pointers and level; abort flushes everything back to empty
  always_ff @(posedge Ck) begin
    if (Reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else if (abort) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Sequencing: load a command from the head, hold it for rep+1 cycles, then chain or idle
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    mode_d   = mode_q;
    din_d    = din_q;
    sin_d    = sin_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop      = 1'b1;
          mode_d   = headCmd.mode;
          din_d    = headCmd.data;
          sin_d    = headCmd.sin;
          remain_d = headCmd.rep;
          state_d  = EXEC;
        end else begin
          mode_d = 3'b000;
          din_d  = 4'b0000;
          sin_d  = 1'b0;
        end
      end
      EXEC: begin
        if (remain_q != 4'd0) begin
          remain_d = remain_q - 4'd1;
        end else begin
          done_d = 1'b1;
          if (!fifoEmpty) begin
            pop      = 1'b1;
            mode_d   = headCmd.mode;
            din_d    = headCmd.data;
            sin_d    = headCmd.sin;
            remain_d = headCmd.rep;
          end else begin
            mode_d  = 3'b000;
            din_d   = 4'b0000;
            sin_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      remain_d = 4'd0;
      mode_d   = 3'b000;
      din_d    = 4'b0000;
      sin_d    = 1'b0;
      done_d   = 1'b0;
      pop      = 1'b0;
    end
  end

  // Sequencer state and registered Counter4 controls
  always_ff @(posedge Ck) begin
    if (Reset) begin
      state_q  <= IDLE;
      remain_q <= 4'd0;
      mode_q   <= 3'b000;
      din_q    <= 4'b0000;
      sin_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      mode_q   <= mode_d;
      din_q    <= din_d;
      sin_q    <= sin_d;
      done_q   <= done_d;
    end
  end

  assign Mode  = mode_q;
  assign Din   = din_q;
  assign R_In  = sin_q;
  assign L_In  = sin_q;
  assign busy  = (state_q == EXEC);
  assign done  = done_q;
  assign level = level_q;

endmodule

// File: tb/tb_counter4_sequencer.sv
// Directed bench for counter4_sequencer with a small Counter4 register model on its outputs.
module tb_counter4_sequencer;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] UP   = 3'b010;
  localparam logic [2:0] DOWN = 3'b011;
  localparam logic [2:0] SHR  = 3'b100;
  localparam logic [2:0] SHL  = 3'b101;
  localparam logic [2:0] COMP = 3'b110;
  localparam logic [2:0] SWAP = 3'b111;

  logic       Ck;
  logic       Reset;
  logic       abort;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_data;
  logic [3:0] cmd_rep;
  logic       cmd_sin;
  logic [2:0] Mode;
  logic [3:0] Din;
  logic       R_In;
  logic       L_In;
  logic       busy;
  logic       done;
  logic [2:0] level;

  logic       plantInit;
  logic [3:0] plantVal;
  logic [3:0] plantQ;

  int checkCount;
  int failCount;
  int accepted;
  int activeCycles;
  int doneCount;
  int doneTick;
  logic doneSeen;

  counter4_sequencer #(.DEPTH(4), .AW(2)) dut (
    .Ck(Ck), .Reset(Reset), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_rep(cmd_rep), .cmd_sin(cmd_sin),
    .Mode(Mode), .Din(Din), .R_In(R_In), .L_In(L_In),
    .busy(busy), .done(done), .level(level)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  // Counter4 register model driven by the sequencer outputs
  always @(posedge Ck) begin
    if (plantInit) plantQ <= plantVal;
    else begin
      case (Mode)
        LOAD:    plantQ <= Din;
        UP:      plantQ <= plantQ + 4'd1;
        DOWN:    plantQ <= plantQ - 4'd1;
        SHR:     plantQ <= {R_In, plantQ[3:1]};
        SHL:     plantQ <= {plantQ[2:0], L_In};
        COMP:    plantQ <= ~plantQ;
        SWAP:    plantQ <= {plantQ[1:0], plantQ[3:2]};
        default: plantQ <= plantQ;
      endcase
    end
  end

  task automatic tick();
    @(posedge Ck);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] m, input logic [3:0] d,
                               input logic [3:0] r, input logic s);
    cmd_valid = v;
    cmd_mode  = m;
    cmd_data  = d;
    cmd_rep   = r;
    cmd_sin   = s;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setPlant(input logic [3:0] v);
    plantVal  = v;
    plantInit = 1'b1;
    tick();
    plantInit = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    abort      = 1'b0;
    plantInit  = 1'b1;
    plantVal   = 4'd0;
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    Reset = 1'b1;
    tick();
    tick();
    Reset     = 1'b0;
    plantInit = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_mode", 8'(Mode), 8'd0);
    checkOutput("rst_din", 8'(Din), 8'd0);
    checkOutput("rst_rin", 8'(R_In), 8'd0);
    checkOutput("rst_lin", 8'(L_In), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_done", 8'(done), 8'd0);
    checkOutput("rst_level", 8'(level), 8'd0);
    checkOutput("rst_ready", 8'(cmd_ready), 8'd1);

    $display("[TB] load then count");
    applyStimulus(1'b1, LOAD, 4'd5, 4'd0, 1'b0);
    tick();
    checkOutput("lc_level_k", 8'(level), 8'd1);
    applyStimulus(1'b1, UP, 4'd0, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    checkOutput("lc_mode_load", 8'(Mode), 8'(LOAD));
    checkOutput("lc_din", 8'(Din), 8'd5);
    checkOutput("lc_busy1", 8'(busy), 8'd1);
    checkOutput("lc_level_k1", 8'(level), 8'd1);
    tick();
    checkOutput("lc_reg5", 8'(plantQ), 8'd5);
    checkOutput("lc_mode_up", 8'(Mode), 8'(UP));
    checkOutput("lc_done1", 8'(done), 8'd1);
    checkOutput("lc_busy2", 8'(busy), 8'd1);
    checkOutput("lc_level0", 8'(level), 8'd0);
    tick();
    checkOutput("lc_reg6", 8'(plantQ), 8'd6);
    checkOutput("lc_done_lo", 8'(done), 8'd0);
    checkOutput("lc_busy3", 8'(busy), 8'd1);
    tick();
    checkOutput("lc_reg7", 8'(plantQ), 8'd7);
    checkOutput("lc_busy4", 8'(busy), 8'd1);
    tick();
    checkOutput("lc_reg8", 8'(plantQ), 8'd8);
    checkOutput("lc_done2", 8'(done), 8'd1);
    checkOutput("lc_busy_end", 8'(busy), 8'd0);
    checkOutput("lc_mode_end", 8'(Mode), 8'd0);
    tick();
    checkOutput("lc_hold8", 8'(plantQ), 8'd8);
    checkOutput("lc_done_end", 8'(done), 8'd0);

    $display("[TB] shift sequence");
    applyStimulus(1'b1, LOAD, 4'b1001, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b1, SHL, 4'd0, 4'd1, 1'b1);
    tick();
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    checkOutput("sh_mode_load", 8'(Mode), 8'(LOAD));
    checkOutput("sh_din", 8'(Din), 8'd9);
    tick();
    checkOutput("sh_reg1001", 8'(plantQ), 8'b1001);
    checkOutput("sh_mode_shl", 8'(Mode), 8'(SHL));
    checkOutput("sh_rin", 8'(R_In), 8'd1);
    checkOutput("sh_lin", 8'(L_In), 8'd1);
    tick();
    checkOutput("sh_reg0011", 8'(plantQ), 8'b0011);
    tick();
    checkOutput("sh_reg0111", 8'(plantQ), 8'b0111);
    checkOutput("sh_mode_end", 8'(Mode), 8'd0);
    checkOutput("sh_lin_end", 8'(L_In), 8'd0);
    checkOutput("sh_done", 8'(done), 8'd1);
    tick();
    checkOutput("sh_hold", 8'(plantQ), 8'b0111);

    $display("[TB] full fifo");
    accepted = 0;
    doneSeen = 1'b0;
    applyStimulus(1'b1, NOP, 4'd0, 4'd15, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready) accepted++;
      tick();
    end
    checkOutput("ff_level4", 8'(level), 8'd4);
    checkOutput("ff_ready0", 8'(cmd_ready), 8'd0);
    checkOutput("ff_busy", 8'(busy), 8'd1);
    for (int i = 0; i < 30 && !doneSeen; i++) begin
      if (cmd_ready) accepted++;
      tick();
      if (done) doneSeen = 1'b1;
    end
    checkOutput("ff_done_seen", 8'(doneSeen), 8'd1);
    checkOutput("ff_accepted", 8'(accepted), 8'd5);
    checkOutput("ff_level_after", 8'(level), 8'd3);
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("ff_flush_level", 8'(level), 8'd0);
    checkOutput("ff_flush_busy", 8'(busy), 8'd0);

    $display("[TB] abort mid-command");
    setPlant(4'd0);
    applyStimulus(1'b1, DOWN, 4'd0, 4'd10, 1'b0);
    tick();
    applyStimulus(1'b1, NOP, 4'd0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b1, UP, 4'd0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    checkOutput("ab_reg15", 8'(plantQ), 8'd15);
    checkOutput("ab_level2", 8'(level), 8'd2);
    tick();
    tick();
    checkOutput("ab_reg13", 8'(plantQ), 8'd13);
    abort = 1'b1;
    applyStimulus(1'b1, LOAD, 4'd7, 4'd0, 1'b0);
    #1;
    checkOutput("ab_ready_lo", 8'(cmd_ready), 8'd0);
    tick();
    abort = 1'b0;
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    checkOutput("ab_reg12", 8'(plantQ), 8'd12);
    checkOutput("ab_level0", 8'(level), 8'd0);
    checkOutput("ab_busy0", 8'(busy), 8'd0);
    checkOutput("ab_mode0", 8'(Mode), 8'd0);
    checkOutput("ab_done0", 8'(done), 8'd0);
    tick();
    checkOutput("ab_hold12", 8'(plantQ), 8'd12);
    checkOutput("ab_no_done", 8'(done), 8'd0);
    checkOutput("ab_idle", 8'(busy), 8'd0);

    $display("[TB] reset during exec");
    applyStimulus(1'b1, NOP, 4'hA, 4'd5, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    checkOutput("re_level3", 8'(level), 8'd3);
    checkOutput("re_din", 8'(Din), 8'd10);
    checkOutput("re_rin", 8'(R_In), 8'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("re_mode", 8'(Mode), 8'd0);
    checkOutput("re_din0", 8'(Din), 8'd0);
    checkOutput("re_rin0", 8'(R_In), 8'd0);
    checkOutput("re_lin0", 8'(L_In), 8'd0);
    checkOutput("re_busy", 8'(busy), 8'd0);
    checkOutput("re_done", 8'(done), 8'd0);
    checkOutput("re_level", 8'(level), 8'd0);
    checkOutput("re_ready", 8'(cmd_ready), 8'd1);
    applyStimulus(1'b1, LOAD, 4'd3, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    tick();
    checkOutput("re_new_mode", 8'(Mode), 8'(LOAD));
    tick();
    checkOutput("re_new_reg", 8'(plantQ), 8'd3);
    checkOutput("re_new_done", 8'(done), 8'd1);

    $display("[TB] max repeat");
    setPlant(4'd0);
    applyStimulus(1'b1, COMP, 4'd0, 4'd15, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 4'd0, 4'd0, 1'b0);
    activeCycles = 0;
    doneCount    = 0;
    doneTick     = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (Mode == COMP) activeCycles++;
      if (done) begin
        doneCount++;
        doneTick = i;
      end
    end
    checkOutput("mr_active", 8'(activeCycles), 8'd16);
    checkOutput("mr_done_count", 8'(doneCount), 8'd1);
    checkOutput("mr_done_tick", 8'(doneTick), 8'd17);
    checkOutput("mr_reg", 8'(plantQ), 8'd0);
    checkOutput("mr_idle", 8'(busy), 8'd0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
